// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, {dev,rw}, ACK, reg, ACK, data, ACK/NACK, STOP.
// SCL and SDA are derived from the state and quarter-bit counter.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL_out,
  output logic       SCL_ena,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       SDA_ena
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_REG      = 4'd4;
  localparam logic [3:0] S_REG_ACK  = 4'd5;
  localparam logic [3:0] S_DATA     = 4'd6;
  localparam logic [3:0] S_DATA_ACK = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qc_q, qc_d;
  logic [2:0]    bit_q, bit_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d, wd_q, wd_d, rx_q, rx_d, rd_data_q, rd_data_d;
  logic          err_q, err_d, ack_err_q, ack_err_d, done_q, done_d;

  logic q_tick, bit_end, samp;
  logic [7:0] tx_byte;
  logic bit_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qc_q      <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wd_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qc_q      <= qc_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wd_q      <= wd_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  assign q_tick  = (div_q == DIV_MAX);
  assign bit_end = q_tick && (qc_q == 2'd3);
  assign samp    = (div_q == '0) && (qc_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qc_d      = qc_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wd_d      = wd_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE) begin
      // A start coinciding with the done pulse is deliberately dropped.
      if (start && !done_q) begin
        state_d   = S_START;
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wd_d      = wr_data;
        err_d     = 1'b0;
        ack_err_d = 1'b0;
        div_d     = '0;
        qc_d      = '0;
        bit_d     = '0;
      end
    end else begin
      if (q_tick) begin
        div_d = '0;
        qc_d  = qc_q + 2'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (samp) begin
        case (state_q)
          S_ADDR_ACK, S_REG_ACK: if (SDA_in) err_d = 1'b1;
          S_DATA_ACK:            if (SDA_in && !rw_q) err_d = 1'b1;
          S_DATA:                if (rw_q) rx_d = {rx_q[6:0], SDA_in};
          default: ;
        endcase
      end
      if (bit_end) begin
        case (state_q)
          S_START: begin state_d = S_ADDR; bit_d = '0; end
          S_ADDR, S_REG, S_DATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = state_q + 4'd1;
          end
          S_ADDR_ACK: state_d = err_q ? S_STOP : S_REG;
          S_REG_ACK:  state_d = err_q ? S_STOP : S_DATA;
          S_DATA_ACK: begin
            if (rw_q) rd_data_d = rx_q;
            state_d = S_STOP;
          end
          S_STOP: begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            ack_err_d = err_q;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (state_q)
      S_ADDR:  tx_byte = {dev_q, rw_q};
      S_REG:   tx_byte = reg_q;
      default: tx_byte = wd_q;
    endcase
  end
  assign bit_val = tx_byte[3'd7 - bit_q];

  // START pulls SDA low in q2 and STOP releases it in q2, both while SCL is high.
  always_comb begin
    SCL_out = 1'b1;
    SDA_ena = 1'b0;
    case (state_q)
      S_IDLE:  SCL_out = 1'b1;
      S_START: begin SCL_out = (qc_q != 2'd3); SDA_ena = qc_q[1]; end
      S_STOP:  begin SCL_out = (qc_q != 2'd0); SDA_ena = !qc_q[1]; end
      S_ADDR, S_REG: begin SCL_out = (qc_q == 2'd1) || (qc_q == 2'd2); SDA_ena = !bit_val; end
      S_DATA:  begin SCL_out = (qc_q == 2'd1) || (qc_q == 2'd2); SDA_ena = !rw_q && !bit_val; end
      default: SCL_out = (qc_q == 2'd1) || (qc_q == 2'd2);
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign SCL_ena = busy;
  assign SDA_out = 1'b0;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: bus monitor plus a simple responder on the CLK_DIV=4
// instance, and two NACK-only instances at CLK_DIV=1 and 8 for timing checks.
module tb_i2c_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wr_data = '0;
  logic [7:0] rd_data;
  logic       busy, done, ack_err, scl_o, scl_e, sda_o, sda_e;
  logic       resp_pull = 1'b0;
  logic       scl_bus, sda_bus;
  assign scl_bus = scl_e ? scl_o : 1'b1;
  assign sda_bus = !(sda_e || resp_pull);

  i2c_master #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .ack_err(ack_err), .SCL_out(scl_o), .SCL_ena(scl_e),
    .SDA_in(sda_bus), .SDA_out(sda_o), .SDA_ena(sda_e));

  logic       start1 = 1'b0, start8 = 1'b0;
  logic [7:0] rd1, rd8;
  logic       busy1, busy8, done1, done8, ae1, ae8;
  logic       scl_o1, scl_e1, sda_o1, sda_e1, scl_o8, scl_e8, sda_o8, sda_e8;

  i2c_master #(.CLK_DIV(1)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd1), .busy(busy1),
    .done(done1), .ack_err(ae1), .SCL_out(scl_o1), .SCL_ena(scl_e1),
    .SDA_in(!sda_e1), .SDA_out(sda_o1), .SDA_ena(sda_e1));
  i2c_master #(.CLK_DIV(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd8), .busy(busy8),
    .done(done8), .ack_err(ae8), .SCL_out(scl_o8), .SCL_ena(scl_e8),
    .SDA_in(!sda_e8), .SDA_out(sda_o8), .SDA_ena(sda_e8));

  logic sel = 1'b0;
  logic scl_s, sda_s, done_s, ae_s;
  assign scl_s  = sel ? (scl_e8 ? scl_o8 : 1'b1) : (scl_e1 ? scl_o1 : 1'b1);
  assign sda_s  = sel ? !sda_e8 : !sda_e1;
  assign done_s = sel ? done8 : done1;
  assign ae_s   = sel ? ae8 : ae1;

  int checks = 0, errors = 0;

  // Bus monitor: bit index counts SCL rising edges since the last START.
  int bitcnt = 0, n_start = 0, n_stop = 0, n_done = 0;
  logic [31:0] bits = '0;
  logic [7:0]  resp_val = 8'h00;
  logic        resp_ack = 1'b1;

  always @(negedge sda_bus) if (scl_bus) begin bitcnt = 0; n_start++; bits = '0; end
  always @(posedge sda_bus) if (scl_bus) n_stop++;
  always @(posedge scl_bus) begin
    if (bitcnt < 32) bits[bitcnt] = sda_bus;
    bitcnt++;
  end
  always @(negedge scl_bus) begin
    resp_pull = 1'b0;
    if (bitcnt == 8 || bitcnt == 17) resp_pull = resp_ack;
    else if (bitcnt >= 18 && bitcnt <= 25 && bits[7]) resp_pull = !resp_val[25 - bitcnt];
    else if (bitcnt == 26 && !bits[7]) resp_pull = resp_ack;
  end
  always @(negedge clk) if (done) n_done++;

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bits[k + i]};
    return b;
  endfunction

  task automatic run_frame(input logic r, input logic [6:0] dv, input logic [7:0] rg,
                           input logic [7:0] wd, output int lat);
    @(negedge clk);
    start = 1'b1; rw = r; dev_addr = dv; reg_addr = rg; wr_data = wd;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b ack_err=%b want 0 0 0", busy, done, ack_err); end
    checks++; if (rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (scl_e !== 1'b0 || sda_e !== 1'b0 || scl_o !== 1'b1 || sda_o !== 1'b0) begin
      errors++; $display("FAIL reset_lines scl_e=%b sda_e=%b scl_o=%b sda_o=%b want 0 0 1 0",
                          scl_e, sda_e, scl_o, sda_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int lat;
    n_done = 0; n_start = 0; n_stop = 0;
    run_frame(1'b0, 7'h33, 8'h01, 8'h2A, lat);
    checks++; if (lat !== 465) begin errors++; $display("FAIL wr_latency got %0d want 465", lat); end
    checks++; if ({byte_at(0), byte_at(9), byte_at(18)} !== 24'h66012A) begin
      errors++; $display("FAIL wr_bytes got %h %h %h want 66 01 2A", byte_at(0), byte_at(9), byte_at(18)); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err got %b want 0", ack_err); end
    repeat (10) @(negedge clk);
    checks++; if (n_done !== 1 || n_start !== 1 || n_stop !== 1 || bitcnt !== 28) begin
      errors++; $display("FAIL wr_bus done=%0d start=%0d stop=%0d edges=%0d want 1 1 1 28",
                          n_done, n_start, n_stop, bitcnt); end
  endtask

  task automatic test_read;
    int lat;
    n_done = 0; n_stop = 0;
    resp_val = 8'h15;
    run_frame(1'b1, 7'h33, 8'h02, 8'hFF, lat);
    checks++; if (lat !== 465) begin errors++; $display("FAIL rd_latency got %0d want 465", lat); end
    checks++; if (byte_at(0) !== 8'h67 || byte_at(9) !== 8'h02) begin
      errors++; $display("FAIL rd_hdr got %h %h want 67 02", byte_at(0), byte_at(9)); end
    checks++; if (rd_data !== 8'h15) begin errors++; $display("FAIL rd_data got %h want 15", rd_data); end
    checks++; if (bits[26] !== 1'b1 || ack_err !== 1'b0) begin
      errors++; $display("FAIL rd_nack master_ack=%b ack_err=%b want 1 0", bits[26], ack_err); end
    repeat (10) @(negedge clk);
    checks++; if (n_stop !== 1 || n_done !== 1) begin
      errors++; $display("FAIL rd_stop stop=%0d done=%0d want 1 1", n_stop, n_done); end
  endtask

  task automatic test_addr_nack;
    int lat;
    n_done = 0; n_stop = 0;
    resp_ack = 1'b0;
    run_frame(1'b0, 7'h12, 8'h01, 8'h55, lat);
    checks++; if (lat !== 177) begin errors++; $display("FAIL nack_latency got %0d want 177", lat); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b want 1", ack_err); end
    checks++; if (bitcnt !== 10 || byte_at(0) !== 8'h24) begin
      errors++; $display("FAIL nack_bits edges=%0d addr=%h want 10 24", bitcnt, byte_at(0)); end
    checks++; if (rd_data !== 8'h15) begin errors++; $display("FAIL nack_rd_data got %h want 15", rd_data); end
    repeat (10) @(negedge clk);
    checks++; if (n_stop !== 1 || n_done !== 1) begin
      errors++; $display("FAIL nack_stop stop=%0d done=%0d want 1 1", n_stop, n_done); end
    resp_ack = 1'b1;
  endtask

  task automatic test_start_ignored;
    int lat;
    n_done = 0;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; dev_addr = 7'h33; reg_addr = 8'h01; wr_data = 8'h2A;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clk); lat++;
      if (lat == 100) begin start = 1'b1; rw = 1'b1; dev_addr = 7'h55; reg_addr = 8'h7F; wr_data = 8'hC3; end
      if (lat == 101) start = 1'b0;
    end
    checks++; if (lat !== 465) begin errors++; $display("FAIL ign_latency got %0d want 465", lat); end
    checks++; if ({byte_at(0), byte_at(9), byte_at(18)} !== 24'h66012A) begin
      errors++; $display("FAIL ign_bytes got %h %h %h want 66 01 2A", byte_at(0), byte_at(9), byte_at(18)); end
    repeat (20) @(negedge clk);
    checks++; if (n_done !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_done done=%0d busy=%b want 1 0", n_done, busy); end
  endtask

  task automatic test_reset_mid;
    int lat;
    n_done = 0;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; dev_addr = 7'h33; reg_addr = 8'hF0; wr_data = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (scl_e !== 1'b0 || sda_e !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_lines scl_e=%b sda_e=%b busy=%b want 0 0 0", scl_e, sda_e, busy); end
    resp_pull = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", n_done); end
    run_frame(1'b0, 7'h33, 8'h00, 8'hA5, lat);
    checks++; if (lat !== 465 || ack_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rerun lat=%0d ack_err=%b want 465 0", lat, ack_err); end
    checks++; if ({byte_at(0), byte_at(9), byte_at(18)} !== 24'h6600A5) begin
      errors++; $display("FAIL rst_mid_bytes got %h %h %h want 66 00 A5", byte_at(0), byte_at(9), byte_at(18)); end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_frame(1'b0, 7'h33, 8'h02, 8'h11, lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignore busy=%b want 0", busy); end
    start = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want 1", busy); end
    lat = 1;
    while (!done && lat < 2000) begin @(negedge clk); lat++; end
    checks++; if (lat !== 465 || byte_at(18) !== 8'h3C) begin
      errors++; $display("FAIL b2b_frame lat=%0d data=%h want 465 3C", lat, byte_at(18)); end
  endtask

  task automatic test_clkdiv(input logic s8, input int div);
    int lat, run, nruns, bad, hi_edges;
    logic pscl, psda, inrun;
    sel = s8;
    @(negedge clk);
    dev_addr = 7'h12; rw = 1'b0;
    if (s8) start8 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    lat = 1; run = 0; nruns = 0; bad = 0; hi_edges = 0; inrun = 1'b0;
    pscl = scl_s; psda = sda_s;
    while (!done_s && lat < 2000) begin
      @(negedge clk); lat++;
      if (scl_s && !pscl) begin inrun = 1'b1; run = 0; end
      if (scl_s) run++;
      if (!scl_s && pscl && inrun) begin nruns++; if (run != 2 * div) bad++; inrun = 1'b0; end
      if (scl_s && pscl && (sda_s != psda)) hi_edges++;
      pscl = scl_s; psda = sda_s;
    end
    checks++; if (lat !== 44 * div + 1 || ae_s !== 1'b1) begin
      errors++; $display("FAIL div%0d_frame lat=%0d ack_err=%b want %0d 1", div, lat, ae_s, 44 * div + 1); end
    checks++; if (nruns !== 9 || bad !== 0) begin
      errors++; $display("FAIL div%0d_scl_high pulses=%0d wrong=%0d want 9 0", div, nruns, bad); end
    checks++; if (hi_edges !== 2) begin
      errors++; $display("FAIL div%0d_sda_while_scl_high got %0d want 2", div, hi_edges); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_clkdiv(1'b0, 1);
    test_clkdiv(1'b1, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
